// File: rtl/alu_seq_param_if.sv
// alu_seq_param_if
//   Request/response bundle for the sequential ALU.
//   Requester -> ALU : start, alu_op[2:0], a[WIDTH-1:0], b[WIDTH-1:0]
//   ALU -> requester : busy, done, res[WIDTH-1:0], hi[WIDTH-1:0], zero, overflow
//   master modport: the requester side (register-read / datapath control).
//   slave  modport: the ALU itself.
interface alu_seq_param_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             overflow;

    modport master (
        output start, alu_op, a, b,
        input  busy, done, res, hi, zero, overflow
    );

    modport slave (
        input  start, alu_op, a, b,
        output busy, done, res, hi, zero, overflow
    );
endinterface

// File: rtl/alu_seq_param.sv
// alu_seq_param
//   Registered ALU with a start/done handshake. Single-cycle ops (add, xor,
//   sub, slt, nor, and, or) register their result at the start edge and pulse
//   done the following cycle. mult runs an unsigned shift-add loop over WIDTH
//   edges and returns the 2*WIDTH-bit product as {hi, res}.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset; aborts any multiply in flight
//     bus   - alu_seq_param_if.slave (start/alu_op/a/b in; busy/done/res/hi/
//             zero/overflow out)
module alu_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_seq_param_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MULT = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_OR   = 3'b111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    logic [0:0]         state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0]   res_q,    res_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic               zero_q,   zero_d;
    logic               ovf_q,    ovf_d;
    logic               done_q,   done_d;

    // ---------------- single-cycle ALU ----------------
    logic [WIDTH-1:0] alu_sum, alu_diff, alu_res;
    logic             alu_ovf;

    assign alu_sum  = bus.a + bus.b;
    assign alu_diff = bus.a - bus.b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                alu_res = alu_sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (alu_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = alu_diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (alu_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_NOR: alu_res = ~(bus.a | bus.b);
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            default: alu_res = '0;   // mult handled by the sequencer
        endcase
    end

    // ---------------- multiply step ----------------
    // Accumulator after this edge's conditional add; on the final edge this
    // is the finished product, so it is written out directly.
    logic [2*WIDTH-1:0] acc_step;
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // ---------------- sequencer ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        res_d    = res_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.alu_op == OP_MULT) begin
                        mcand_d  = {{WIDTH{1'b0}}, bus.a};
                        mplier_d = bus.b;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = ST_MUL;
                    end else begin
                        res_d  = alu_res;
                        hi_d   = '0;
                        zero_d = (alu_res == '0);
                        ovf_d  = alu_ovf;
                        done_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // start/a/b/alu_op are ignored here: operands were latched
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    {hi_d, res_d} = acc_step;
                    zero_d  = (acc_step == '0);
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy     = (state_q == ST_MUL);
    assign bus.done     = done_q;
    assign bus.res      = res_q;
    assign bus.hi       = hi_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param
//   Directed bench for alu_seq_param at WIDTH=32. Inputs change on the falling
//   edge, outputs are sampled on the falling edge after the active edge.
module tb_alu_seq_param;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    alu_seq_param_if #(.WIDTH(32)) bus ();

    alu_seq_param #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One single-cycle op: present at a falling edge, take it at the next
    // rising edge, sample the registered result at the following falling edge.
    task automatic op1(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        bus.start  = 1'b1;
        bus.alu_op = op;
        bus.a      = va;
        bus.b      = vb;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Launch a multiply, then watch 40 cycles. i counts falling edges after
    // the start edge; done at i==32 means WIDTH cycles of latency. At
    // i==poke_at a conflicting add request is presented for one cycle.
    task automatic run_mul(input logic [31:0] ma, input logic [31:0] mb, input int poke_at,
                           output int done_at, output int busy_cnt, output int done_cnt);
        bus.start  = 1'b1;
        bus.alu_op = 3'b011;
        bus.a      = ma;
        bus.b      = mb;
        done_at    = -1;
        busy_cnt   = 0;
        done_cnt   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            bus.start = (i == poke_at);
            if (i == poke_at) begin
                bus.alu_op = 3'b000;
                bus.a      = 32'd1;
                bus.b      = 32'd1;
            end
        end
    endtask

    initial begin
        int done_at, busy_cnt, done_cnt;
        int busy_seen;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start  = 1'b0;
        bus.alu_op = 3'b000;
        bus.a      = '0;
        bus.b      = '0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_res",  64'(bus.res),  64'd0);
        chk("rst_hi",   64'(bus.hi),   64'd0);
        chk("rst_zero", 64'(bus.zero), 64'd0);
        chk("rst_ovf",  64'(bus.overflow), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- add 13+12 ----
        busy_seen = 0;
        op1(3'b000, 32'd13, 32'd12);
        busy_seen |= int'(bus.busy);
        chk("add_done", 64'(bus.done), 64'd1);
        chk("add_res",  64'(bus.res),  64'd25);
        chk("add_zero", 64'(bus.zero), 64'd0);
        chk("add_ovf",  64'(bus.overflow), 64'd0);
        chk("add_hi",   64'(bus.hi),   64'd0);
        @(negedge clk);
        busy_seen |= int'(bus.busy);
        chk("add_done_pulse", 64'(bus.done), 64'd0);
        chk("add_res_hold",   64'(bus.res),  64'd25);
        chk("add_busy_never", 64'(busy_seen), 64'd0);

        // ---- sub of equal operands ----
        op1(3'b010, 32'h8000000D, 32'h8000000D);
        chk("sub_res",  64'(bus.res),  64'd0);
        chk("sub_zero", 64'(bus.zero), 64'd1);
        chk("sub_ovf",  64'(bus.overflow), 64'd0);

        // ---- add signed overflow ----
        op1(3'b000, 32'h7FFFFFFF, 32'h1);
        chk("addov_res",  64'(bus.res),  64'h80000000);
        chk("addov_ovf",  64'(bus.overflow), 64'd1);
        chk("addov_zero", 64'(bus.zero), 64'd0);

        // ---- sub signed overflow: 0x80000000 - 1 ----
        op1(3'b010, 32'h80000000, 32'h1);
        chk("subov_res", 64'(bus.res), 64'h7FFFFFFF);
        chk("subov_ovf", 64'(bus.overflow), 64'd1);

        // ---- slt signed ----
        op1(3'b100, 32'h80000000, 32'h1);
        chk("slt_neg",  64'(bus.res), 64'd1);
        chk("slt_ovf",  64'(bus.overflow), 64'd0);
        op1(3'b100, 32'h0200000D, 32'h0200000C);
        chk("slt_gt",   64'(bus.res), 64'd0);
        chk("slt_zero", 64'(bus.zero), 64'd1);

        // ---- bitwise ops, start held high: done every cycle ----
        bus.start = 1'b1;
        bus.alu_op = 3'b001; bus.a = 32'hF0F0_1234; bus.b = 32'h0FF0_FFFF;
        @(negedge clk);
        chk("xor_res",  64'(bus.res), 64'hFF00_EDCB);
        chk("xor_done", 64'(bus.done), 64'd1);
        bus.alu_op = 3'b101; bus.a = 32'h0; bus.b = 32'h0;
        @(negedge clk);
        chk("nor_res",  64'(bus.res), 64'hFFFF_FFFF);
        chk("nor_done", 64'(bus.done), 64'd1);
        bus.alu_op = 3'b110; bus.a = 32'hFF00_FF00; bus.b = 32'h0F0F_0F0F;
        @(negedge clk);
        chk("and_res",  64'(bus.res), 64'h0F00_0F00);
        bus.alu_op = 3'b111; bus.a = 32'hA000_0005; bus.b = 32'h0500_0050;
        @(negedge clk);
        chk("or_res",   64'(bus.res), 64'hA500_0055);
        chk("or_done",  64'(bus.done), 64'd1);
        bus.start = 1'b0;
        @(negedge clk);

        // ---- mult 13*12 ----
        run_mul(32'd13, 32'd12, -1, done_at, busy_cnt, done_cnt);
        chk("mul1_done_at", 64'(done_at),  64'd32);
        chk("mul1_busy",    64'(busy_cnt), 64'd32);
        chk("mul1_ndone",   64'(done_cnt), 64'd1);
        chk("mul1_res",     64'(bus.res),  64'd156);
        chk("mul1_hi",      64'(bus.hi),   64'd0);
        chk("mul1_zero",    64'(bus.zero), 64'd0);

        // ---- mult max*max ----
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, -1, done_at, busy_cnt, done_cnt);
        chk("mul2_done_at", 64'(done_at), 64'd32);
        chk("mul2_hi",      64'(bus.hi),  64'hFFFFFFFE);
        chk("mul2_res",     64'(bus.res), 64'h00000001);
        chk("mul2_zero",    64'(bus.zero), 64'd0);
        chk("mul2_ovf",     64'(bus.overflow), 64'd0);

        // ---- mult 0*5 ----
        run_mul(32'd0, 32'd5, -1, done_at, busy_cnt, done_cnt);
        chk("mul3_res",  64'(bus.res),  64'd0);
        chk("mul3_hi",   64'(bus.hi),   64'd0);
        chk("mul3_zero", 64'(bus.zero), 64'd1);

        // ---- start during busy is ignored ----
        run_mul(32'd1000, 32'd3, 5, done_at, busy_cnt, done_cnt);
        chk("busyp_done_at", 64'(done_at),  64'd32);
        chk("busyp_ndone",   64'(done_cnt), 64'd1);
        chk("busyp_res",     64'(bus.res),  64'd3000);
        chk("busyp_hi",      64'(bus.hi),   64'd0);

        // ---- reset mid-multiply ----
        bus.start = 1'b1; bus.alu_op = 3'b011; bus.a = 32'd77; bus.b = 32'd99;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("rmid_busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rmid_busy", 64'(bus.busy), 64'd0);
        chk("rmid_done", 64'(bus.done), 64'd0);
        chk("rmid_res",  64'(bus.res),  64'd0);
        chk("rmid_hi",   64'(bus.hi),   64'd0);
        chk("rmid_zero", 64'(bus.zero), 64'd0);
        chk("rmid_ovf",  64'(bus.overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cnt++;
        end
        chk("rmid_no_done", 64'(done_cnt), 64'd0);
        chk("rmid_no_busy", 64'(busy_cnt), 64'd0);
        op1(3'b000, 32'd7, 32'd8);
        chk("rpost_done", 64'(bus.done), 64'd1);
        chk("rpost_res",  64'(bus.res),  64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
